// File: rtl/lfsr_engine_if.sv
// Control and observation bundle for lfsr_engine.
// The master drives load/seed/step/mode; the slave (the engine) returns state and status.
interface lfsr_engine_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] y;
  logic             bit_out;
  logic             wrap;
  logic [WIDTH-1:0] period;
  logic             seed_err;

  modport master (
    output load, seed_in, en, mode,
    input  y, bit_out, wrap, period, seed_err
  );

  modport slave (
    input  load, seed_in, en, mode,
    output y, bit_out, wrap, period, seed_err
  );
endinterface

// File: rtl/lfsr_engine.sv
// Parametrised Fibonacci/Galois LFSR with zero-seed guard and a period counter that
// measures the distance back to the reference state captured at load/reset/mode change.
module lfsr_engine #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] FTAPS = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] GTAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01)
) (
  input logic          clk,
  input logic          rst,
  lfsr_engine_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic             seed_err_q, seed_err_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] cnt_inc;

  always_comb begin
    fib_next  = {^(y_q & FTAPS), y_q[WIDTH-1:1]};
    gal_next  = (y_q >> 1) ^ (y_q[0] ? GTAPS : '0);
    step_next = bus.mode ? gal_next : fib_next;
    // Saturating increment: a sequence that never returns reports all-ones.
    cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
  end

  always_comb begin
    y_d        = y_q;
    ref_d      = ref_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    wrap_d     = 1'b0;
    seed_err_d = seed_err_q;
    mode_d     = mode_q;

    if (bus.load) begin
      if (bus.seed_in != '0) begin
        y_d        = bus.seed_in;
        ref_d      = bus.seed_in;
        seed_err_d = 1'b0;
      end else begin
        y_d        = SEED;
        ref_d      = SEED;
        seed_err_d = 1'b1;
      end
      cnt_d = '0;
    end else if (bus.en) begin
      y_d = step_next;
      if (bus.mode != mode_q) begin
        // A new form defines a new cycle, so measurement restarts from here.
        mode_d = bus.mode;
        ref_d  = step_next;
        cnt_d  = '0;
      end else if (step_next == ref_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q        <= SEED;
      ref_q      <= SEED;
      cnt_q      <= '0;
      period_q   <= '0;
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      y_q        <= y_d;
      ref_q      <= ref_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      wrap_q     <= wrap_d;
      seed_err_q <= seed_err_d;
      mode_q     <= mode_d;
    end
  end

  assign bus.y        = y_q;
  assign bus.bit_out  = y_q[0];
  assign bus.wrap     = wrap_q;
  assign bus.period   = period_q;
  assign bus.seed_err = seed_err_q;

endmodule

// File: doc/lfsr_engine.md
# lfsr_engine

Parametrised linear-feedback shift register that generalises the team's 8-bit Fibonacci shifter.
- Width, tap masks and seed are parameters; Fibonacci or Galois form is selectable at run time.
- Zero seeds are guarded so the register cannot lock up.
- A built-in period counter measures the sequence length, reports it, and pulses on every wrap back to the reference state.
- Sits in the pseudo-random / test-pattern datapath of the lab designs and feeds the display or comparison logic with `y`, `wrap` and `period`.

## Interface
- `WIDTH`, 8: state width, ≥ 2.
- `FTAPS`, 8'h1D: Fibonacci tap mask; bit i set means `y[i]` is XORed into the feedback.
- `GTAPS`, 8'hB8: Galois toggle mask, applied when the bit shifted out is 1.
- `SEED`, 8'h01: reset and substitute value; non-zero.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `load`, in, 1: load `seed_in` this cycle.
- `seed_in`, in, WIDTH: value to load.
- `en`, in, 1: advance one step this cycle.
- `mode`, in, 1: 0 = Fibonacci, 1 = Galois.
- `y`, out, WIDTH: current state, registered.
- `bit_out`, out, 1: `y[0]`, combinational from `y`.
- `wrap`, out, 1: 1-cycle pulse, the state has returned to the reference value.
- `period`, out, WIDTH: last measured sequence length.
- `seed_err`, out, 1: sticky flag, a zero seed was substituted.

## Operation
- **Reset (rst = 0):**
  - `y` = SEED, `ref` = SEED, `cnt` = 0.
  - `period` = 0, `wrap` = 0, `seed_err` = 0.
  - `mode_q` = 0.
- **Priority per cycle:** load > mode change > step > hold.
- **Load:**
  - If `seed_in` ≠ 0: `y` = `seed_in`, `ref` = `seed_in`, `seed_err` cleared.
  - If `seed_in` = 0: `y` = SEED, `ref` = SEED, `seed_err` set.
  - In both cases `cnt` = 0 and `wrap` = 0.
  - `en` is ignored that cycle and `period` holds.
- **Step, Fibonacci (`mode` = 0):**
  - `fb` = XOR-reduce(`y` & FTAPS).
  - `y` ← {`fb`, `y[WIDTH-1:1]`}.
- **Step, Galois (`mode` = 1):**
  - `y` ← (`y` >> 1) ^ (`y[0]` ? GTAPS : 0).
- **Mode change:** if `en` = 1 and `mode` ≠ `mode_q`:
  - `mode_q` ← `mode`.
  - The step is taken in the new mode.
  - `ref` ← next `y`, `cnt` ← 0, `wrap` = 0.
  - `period` holds.
  - `mode_q` updates only on steps.
- **Period tracking on a normal step:**
  - If next `y` = `ref`: `wrap` = 1, `period` ← `cnt` + 1, `cnt` ← 0.
  - Otherwise `cnt` ← `cnt` + 1, saturating at all-ones; `wrap` = 0.
  - With `cnt` saturated, a later wrap latches `period` = all-ones.
- **Hold (`en` = 0, no load):** `y`, `cnt`, `ref` and `period` hold; `wrap` = 0.
- **All-zero state:** unreachable, since reset and load never produce 0 and both step forms map non-zero to non-zero. No runtime zero check is required.

## Timing
- Outputs `y`, `wrap`, `period` and `seed_err` are all registered.
- Latency is 1 cycle from an input to its effect; `bit_out` follows `y` combinationally.
- `wrap` is high in the same cycle that `y` shows the `ref` value.
- `period` updates in that same cycle.
- Back-to-back steps every cycle are supported with no bubbles.
- Reset asserted mid-sequence forces the reset values immediately, independent of the clock.
- Reset release is synchronous-safe: the first step may occur on the first rising edge after `rst` goes high.
- `load` and `en` together: the load wins, no step is taken, and `wrap` = 0.

## Test plan
- **Fibonacci sequence:** reset with defaults, hold `en` = 1 in Fibonacci mode → `y` = 01, 80, 40, 20, 10, 88 on successive cycles.
- **Galois sequence:** defaults, `mode` = 1 from reset, `en` = 1 → `y` = 01, B8, 5C, 2E, 17, B3. `cnt` restarts at the first step because of the mode change.
- **Period measurement:** `WIDTH` = 4, `FTAPS` = 4'b0011, `SEED` = 4'h1, Fibonacci mode, 15 steps → `wrap` pulses once on step 15, `period` = 15, `y` = 1. It pulses again on step 30.
- **Zero-seed guard:** `load` = 1 with `seed_in` = 0 → `y` = SEED and `seed_err` = 1. A following load of 8'h5A → `y` = 5A and `seed_err` = 0.
- **Load/step priority and hold:** `load` = 1 with `en` = 1 and `seed_in` = 8'h33 → `y` = 33 with no step. Then `en` = 0 for 3 cycles → `y` stays 33 and `wrap` stays 0.
- **Reset mid-run:** assert `rst` = 0 asynchronously between clock edges after 5 steps → `y` = 01 and `period` = 0 without waiting for an edge. The sequence restarts at 80 after release.
